mips_boot_ctrl: RTL and testbench
=================================

// Module: mips_boot_ctrl
// PURPOSE
//  Boot/run sequencer for SingleCycleClockMIPS. Receives a program as a byte stream (valid/ready),
//  packs bytes into 32-bit words and writes them through the CPU's W_Ins/WE load port while
//  holding the CPU in reset. Then releases the CPU for a bounded run and stops it on halt-PC
//  or timeout. Sits between host/UART front-end and the CPU top.
// PARAMETERS
//  PROG_WORDS  16            words loaded per START; legal range 1..2**CNT_W-1
//  RUN_CYCLES  160           max CPU cycles in RUN before timeout; legal range 1..2**CNT_W-1
//  HALT_PC     32'h0000_FFFC PC value that signals program end
//  CNT_W       16            width of word and run counters
// PORTS
//  CLK       in   1     system clock, rising edge
//  RST_N     in   1     asynchronous active-low reset
//  START     in   1     1-cycle request: begin load; honoured only in IDLE/HALT
//  IN_VALID  in   1     host byte valid
//  IN_DATA   in   8     host byte, big-endian (first byte -> word[31:24])
//  IN_READY  out  1     controller accepts IN_DATA this cycle
//  W_Ins     out  32    instruction word to CPU load port
//  WE        out  1     CPU instruction-memory write strobe, 1-cycle pulse per word
//  CPU_RST   out  1     active-high reset to CPU; 1 except in RUN
//  PC        in   32    CPU program counter
//  DONE      out  1     sticky: run ended (halt or timeout); cleared by START
//  TIMEOUT   out  1     sticky: run ended by cycle budget; cleared by START
//  WORD_CNT  out  CNT_W words written in current load
// BEHAVIOUR
//  All outputs registered. Reset (async, RST_N=0): state=IDLE, IN_READY=0, W_Ins=0, WE=0,
//   CPU_RST=1, DONE=0, TIMEOUT=0, WORD_CNT=0, byte index=0, run count=0. Partial word discarded.
//  States: IDLE, LOAD, RUN, HALT.
//  IDLE: CPU_RST=1. START -> LOAD; WORD_CNT, byte index, run count, DONE, TIMEOUT cleared.
//  LOAD: IN_READY=1 except in a cycle where WE=1. Byte accepted on edge with IN_VALID&IN_READY;
//   IN_VALID without IN_READY holds; no byte lost or duplicated. Byte idx 0..3 (2 bits, wraps).
//   On 4th accepted byte: W_Ins<={b0,b1,b2,b3}, WE=1 for exactly the next cycle, WORD_CNT+1.
//   W_Ins holds its value until the next word.
//   After the WE cycle of word PROG_WORDS -> RUN; IN_READY=0 from that edge.
//  RUN: CPU_RST=0 on first RUN cycle; run count +1 each RUN cycle.
//   PC==HALT_PC sampled -> HALT, DONE=1, TIMEOUT=0.
//   Else run count reaches RUN_CYCLES (exactly RUN_CYCLES cycles with CPU_RST=0) -> HALT,
//    DONE=1, TIMEOUT=1.
//   Halt PC on the final budget cycle: halt wins, TIMEOUT=0.
//  HALT: CPU_RST=1 (CPU frozen), DONE/TIMEOUT held. START -> LOAD with the same clears as in IDLE.
//  START in LOAD/RUN ignored. IN_VALID outside LOAD ignored (IN_READY=0).
//  Counters never wrap within legal parameter range.
// TESTING
//  T1 reset: RST_N=0 mid-LOAD (after 2 bytes) -> immediately CPU_RST=1, WE=0, IN_READY=0,
//     WORD_CNT=0; after release + START, first word built from fresh bytes only.
//  T2 load, PROG_WORDS=2, bytes 20 08 00 05 20 09 00 07 streamed back-to-back ->
//     two 1-cycle WE pulses with W_Ins=32'h20080005 then 32'h20090007; IN_READY=0 in each
//     WE cycle; WORD_CNT=2; CPU_RST falls the cycle after 2nd WE.
//  T3 backpressure: same bytes with IN_VALID gapped randomly (1-3 idle cycles) ->
//     identical WE/W_Ins sequence, no extra WE.
//  T4 halt: after load, drive PC=HALT_PC on 10th RUN cycle -> next edge DONE=1, TIMEOUT=0,
//     CPU_RST=1; START then -> LOAD, DONE=0.
//  T5 timeout: RUN_CYCLES=160, PC never HALT_PC -> CPU_RST low exactly 160 cycles,
//     then DONE=1, TIMEOUT=1.
//  T6 tie: PC=HALT_PC on 160th RUN cycle -> DONE=1, TIMEOUT=0; START pulses during LOAD/RUN
//     -> no effect on state or counters.

Source files
------------

// File: rtl/mips_boot_ctrl.sv
// Boot/run sequencer for SingleCycleClockMIPS: packs a big-endian byte stream into
// instruction words, writes them through the CPU load port, then runs the CPU until halt PC or budget.
module mips_boot_ctrl #(
  parameter int unsigned PROG_WORDS = 16,
  parameter int unsigned RUN_CYCLES = 160,
  parameter logic [31:0] HALT_PC    = 32'h0000_FFFC,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             IN_VALID,
  input  logic [7:0]       IN_DATA,
  output logic             IN_READY,
  output logic [31:0]      W_Ins,
  output logic             WE,
  output logic             CPU_RST,
  input  logic [31:0]      PC,
  output logic             DONE,
  output logic             TIMEOUT,
  output logic [CNT_W-1:0] WORD_CNT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t             state_r;
  logic [1:0]         byte_idx_r;
  logic [23:0]        byte_buf_r;
  logic [CNT_W-1:0]   run_cnt_r;
  logic [CNT_W-1:0]   word_cnt_r;
  logic               in_ready_r;
  logic [31:0]        w_ins_r;
  logic               we_r;
  logic               cpu_rst_r;
  logic               done_r;
  logic               timeout_r;

  logic               byte_take_s;
  logic               halt_hit_s;
  logic               budget_hit_s;
  logic               last_word_s;
  logic [CNT_W-1:0]   run_cnt_nxt_s;
  logic [CNT_W-1:0]   word_cnt_nxt_s;

  // Handshake, halt detection and counter-limit decodes
  always_comb begin
    byte_take_s    = 1'b0;
    halt_hit_s     = 1'b0;
    budget_hit_s   = 1'b0;
    last_word_s    = 1'b0;
    run_cnt_nxt_s  = run_cnt_r + CNT_W'(1);
    word_cnt_nxt_s = word_cnt_r + CNT_W'(1);
    if (state_r == S_LOAD) begin
      byte_take_s = IN_VALID & in_ready_r;
    end else begin
      byte_take_s = 1'b0;
    end
    if (PC == HALT_PC) begin
      halt_hit_s = 1'b1;
    end else begin
      halt_hit_s = 1'b0;
    end
    if (run_cnt_nxt_s == CNT_W'(RUN_CYCLES)) begin
      budget_hit_s = 1'b1;
    end else begin
      budget_hit_s = 1'b0;
    end
    // word_cnt_r is already incremented while WE is high, so this is valid in the WE cycle
    if (word_cnt_r == CNT_W'(PROG_WORDS)) begin
      last_word_s = 1'b1;
    end else begin
      last_word_s = 1'b0;
    end
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r    <= S_IDLE;
      byte_idx_r <= 2'd0;
      byte_buf_r <= 24'd0;
      run_cnt_r  <= '0;
      word_cnt_r <= '0;
      in_ready_r <= 1'b0;
      w_ins_r    <= 32'd0;
      we_r       <= 1'b0;
      cpu_rst_r  <= 1'b1;
      done_r     <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_HALT: begin
          we_r       <= 1'b0;
          cpu_rst_r  <= 1'b1;
          if (START) begin
            state_r    <= S_LOAD;
            byte_idx_r <= 2'd0;
            run_cnt_r  <= '0;
            word_cnt_r <= '0;
            done_r     <= 1'b0;
            timeout_r  <= 1'b0;
            in_ready_r <= 1'b1;
          end else begin
            in_ready_r <= 1'b0;
          end
        end
        S_LOAD: begin
          cpu_rst_r <= 1'b1;
          if (we_r) begin
            we_r <= 1'b0;
            if (last_word_s) begin
              state_r    <= S_RUN;
              cpu_rst_r  <= 1'b0;
              in_ready_r <= 1'b0;
            end else begin
              in_ready_r <= 1'b1;
            end
          end else if (byte_take_s) begin
            byte_idx_r <= byte_idx_r + 2'd1;
            byte_buf_r <= {byte_buf_r[15:0], IN_DATA};
            if (byte_idx_r == 2'd3) begin
              w_ins_r    <= {byte_buf_r, IN_DATA};
              we_r       <= 1'b1;
              in_ready_r <= 1'b0;
              word_cnt_r <= word_cnt_nxt_s;
            end else begin
              in_ready_r <= 1'b1;
            end
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        S_RUN: begin
          run_cnt_r  <= run_cnt_nxt_s;
          in_ready_r <= 1'b0;
          we_r       <= 1'b0;
          // A halt PC on the last budget cycle is a clean halt, not a timeout
          if (halt_hit_s) begin
            state_r   <= S_HALT;
            cpu_rst_r <= 1'b1;
            done_r    <= 1'b1;
            timeout_r <= 1'b0;
          end else if (budget_hit_s) begin
            state_r   <= S_HALT;
            cpu_rst_r <= 1'b1;
            done_r    <= 1'b1;
            timeout_r <= 1'b1;
          end else begin
            cpu_rst_r <= 1'b0;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          in_ready_r <= 1'b0;
          we_r       <= 1'b0;
          cpu_rst_r  <= 1'b1;
        end
      endcase
    end
  end

  assign IN_READY = in_ready_r;
  assign W_Ins    = w_ins_r;
  assign WE       = we_r;
  assign CPU_RST  = cpu_rst_r;
  assign DONE     = done_r;
  assign TIMEOUT  = timeout_r;
  assign WORD_CNT = word_cnt_r;

endmodule

// File: tb/tb_mips_boot_ctrl.sv
// Self-checking bench for mips_boot_ctrl: random byte streams and halt points checked
// against a word-packing and run-length model computed from the sequencer's rules.
module tb_mips_boot_ctrl;

  localparam int          PW   = 2;
  localparam int          RC   = 160;
  localparam logic [31:0] HALT = 32'h0000_FFFC;

  logic        CLK;
  logic        RST_N;
  logic        START;
  logic        IN_VALID;
  logic [7:0]  IN_DATA;
  logic        IN_READY;
  logic [31:0] W_Ins;
  logic        WE;
  logic        CPU_RST;
  logic [31:0] PC;
  logic        DONE;
  logic        TIMEOUT;
  logic [15:0] WORD_CNT;

  int errors = 0;
  int checks = 0;

  logic [7:0]  tx_q[$];
  logic [31:0] we_q[$];
  int          long_we = 0;
  int          rdy_in_we = 0;
  logic        we_prev = 1'b0;

  mips_boot_ctrl #(
    .PROG_WORDS(PW),
    .RUN_CYCLES(RC),
    .HALT_PC   (HALT),
    .CNT_W     (16)
  ) dut (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .START   (START),
    .IN_VALID(IN_VALID),
    .IN_DATA (IN_DATA),
    .IN_READY(IN_READY),
    .W_Ins   (W_Ins),
    .WE      (WE),
    .CPU_RST (CPU_RST),
    .PC      (PC),
    .DONE    (DONE),
    .TIMEOUT (TIMEOUT),
    .WORD_CNT(WORD_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Records every write strobe mid-cycle
  always @(negedge CLK) begin
    if (WE === 1'b1) begin
      we_q.push_back(W_Ins);
      if (we_prev === 1'b1) long_we++;
      if (IN_READY === 1'b1) rdy_in_we++;
    end
    we_prev = WE;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Big-endian packing: byte 4i lands in bits 31:24
  function automatic logic [31:0] exp_word(input int i);
    logic [31:0] w;
    w = (32'(tx_q[4*i]) << 24) | (32'(tx_q[4*i+1]) << 16) |
        (32'(tx_q[4*i+2]) << 8) | 32'(tx_q[4*i+3]);
    return w;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = $urandom;
    if (p == HALT) p = p ^ 32'h1;
    return p;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  // Streams tx_q; ends one cycle after the last accepting edge
  task automatic stream(input bit gapped, input bit noise, output bit ok);
    int  n;
    bit  rdy;
    ok = 1'b1;
    for (int i = 0; i < tx_q.size(); i++) begin
      if (gapped) begin
        IN_VALID = 1'b0;
        IN_DATA  = 8'($urandom);
        repeat ($urandom_range(1, 3)) step();
      end
      IN_VALID = 1'b1;
      IN_DATA  = tx_q[i];
      n   = 0;
      rdy = 1'b0;
      while (!rdy && n < 20) begin
        rdy = (IN_READY === 1'b1);
        if (noise) START = 1'($urandom_range(0, 1));
        step();
        START = 1'b0;
        n++;
      end
      if (!rdy) ok = 1'b0;
    end
    IN_VALID = 1'b0;
    IN_DATA  = 8'($urandom);
  endtask

  task automatic load_program(input bit gapped, input bit noise, output bit ok);
    we_q.delete();
    tx_q.delete();
    long_we   = 0;
    rdy_in_we = 0;
    for (int i = 0; i < 4 * PW; i++) tx_q.push_back(8'($urandom));
    stream(gapped, noise, ok);
    step();
  endtask

  // Counts cycles with CPU_RST low; PC is the halt value only in cycle halt_at
  task automatic run_until_stop(input int halt_at, input bit noise, output int low);
    low = 0;
    while (CPU_RST === 1'b0 && low < 400) begin
      PC = (low + 1 == halt_at) ? HALT : rand_pc();
      if (noise) START = 1'($urandom_range(0, 1));
      step();
      START = 1'b0;
      low++;
    end
    PC = rand_pc();
  endtask

  task automatic test_reset();
    bit ok;
    RST_N = 1'b0; START = 1'b0; IN_VALID = 1'b0; IN_DATA = 8'h00; PC = 32'h0;
    repeat (3) step();
    checks++;
    if (IN_READY !== 1'b0 || WE !== 1'b0 || CPU_RST !== 1'b1 || DONE !== 1'b0 ||
        TIMEOUT !== 1'b0 || WORD_CNT !== 16'd0 || W_Ins !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b we=%b cpu_rst=%b done=%b to=%b cnt=%0d w=%h, required 0 0 1 0 0 0 0",
               IN_READY, WE, CPU_RST, DONE, TIMEOUT, WORD_CNT, W_Ins);
    end
    RST_N = 1'b1;
    repeat (2) step();
    checks++;
    if (IN_READY !== 1'b0 || CPU_RST !== 1'b1) begin
      errors++;
      $display("FAIL idle_outputs: rdy=%b cpu_rst=%b, required 0 1", IN_READY, CPU_RST);
    end
    pulse_start();
    tx_q.delete();
    tx_q.push_back(8'($urandom));
    tx_q.push_back(8'($urandom));
    stream(1'b0, 1'b0, ok);
    checks++;
    if (!ok || IN_READY !== 1'b1 || WORD_CNT !== 16'd0) begin
      errors++;
      $display("FAIL partial_load: ok=%b rdy=%b cnt=%0d, required 1 1 0", ok, IN_READY, WORD_CNT);
    end
    RST_N = 1'b0;
    #1;
    checks++;
    if (CPU_RST !== 1'b1 || WE !== 1'b0 || IN_READY !== 1'b0 || WORD_CNT !== 16'd0) begin
      errors++;
      $display("FAIL async_reset: cpu_rst=%b we=%b rdy=%b cnt=%0d, required 1 0 0 0",
               CPU_RST, WE, IN_READY, WORD_CNT);
    end
    step();
    RST_N = 1'b1;
    step();
  endtask

  task automatic test_load();
    bit ok;
    int low;
    we_q.delete();
    long_we = 0;
    rdy_in_we = 0;
    pulse_start();
    checks++;
    if (IN_READY !== 1'b1 || DONE !== 1'b0) begin
      errors++;
      $display("FAIL load_entry: rdy=%b done=%b, required 1 0", IN_READY, DONE);
    end
    tx_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h20, 8'h09, 8'h00, 8'h07};
    stream(1'b0, 1'b0, ok);
    checks++;
    if (!ok || WE !== 1'b1 || W_Ins !== 32'h2009_0007 || IN_READY !== 1'b0 ||
        WORD_CNT !== 16'd2 || CPU_RST !== 1'b1) begin
      errors++;
      $display("FAIL last_we_cycle: ok=%b we=%b w=%h rdy=%b cnt=%0d cpu_rst=%b, required 1 1 20090007 0 2 1",
               ok, WE, W_Ins, IN_READY, WORD_CNT, CPU_RST);
    end
    step();
    checks++;
    if (CPU_RST !== 1'b0 || WE !== 1'b0 || IN_READY !== 1'b0) begin
      errors++;
      $display("FAIL run_entry: cpu_rst=%b we=%b rdy=%b, required 0 0 0", CPU_RST, WE, IN_READY);
    end
    checks++;
    if (we_q.size() != 2 || we_q[0] !== 32'h2008_0005 || we_q[1] !== 32'h2009_0007 ||
        long_we != 0 || rdy_in_we != 0) begin
      errors++;
      $display("FAIL load_words: n=%0d first=%h long=%0d rdy_in_we=%0d, required 2 20080005 0 0",
               we_q.size(), (we_q.size() > 0) ? we_q[0] : 32'hx, long_we, rdy_in_we);
    end
    run_until_stop(5, 1'b0, low);
    checks++;
    if (low != 5 || DONE !== 1'b1 || TIMEOUT !== 1'b0) begin
      errors++;
      $display("FAIL load_run: low=%0d done=%b to=%b, required 5 1 0", low, DONE, TIMEOUT);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int low;
    pulse_start();
    checks++;
    if (DONE !== 1'b0 || WORD_CNT !== 16'd0) begin
      errors++;
      $display("FAIL bp_start_clear: done=%b cnt=%0d, required 0 0", DONE, WORD_CNT);
    end
    load_program(1'b1, 1'b0, ok);
    checks++;
    if (!ok || CPU_RST !== 1'b0 || we_q.size() != PW || long_we != 0 || rdy_in_we != 0) begin
      errors++;
      $display("FAIL bp_load: ok=%b cpu_rst=%b n=%0d long=%0d rdy_in_we=%0d, required 1 0 %0d 0 0",
               ok, CPU_RST, we_q.size(), long_we, rdy_in_we, PW);
    end
    for (int i = 0; i < we_q.size() && i < PW; i++) begin
      checks++;
      if (we_q[i] !== exp_word(i)) begin
        errors++;
        $display("FAIL bp_word%0d: got %h, required %h", i, we_q[i], exp_word(i));
      end
    end
    run_until_stop(3, 1'b0, low);
    checks++;
    if (low != 3 || DONE !== 1'b1) begin
      errors++;
      $display("FAIL bp_run: low=%0d done=%b, required 3 1", low, DONE);
    end
  endtask

  task automatic test_halt();
    bit ok;
    int low;
    pulse_start();
    load_program(1'b0, 1'b0, ok);
    run_until_stop(10, 1'b0, low);
    checks++;
    if (!ok || low != 10 || DONE !== 1'b1 || TIMEOUT !== 1'b0 || CPU_RST !== 1'b1) begin
      errors++;
      $display("FAIL halt_10: ok=%b low=%0d done=%b to=%b cpu_rst=%b, required 1 10 1 0 1",
               ok, low, DONE, TIMEOUT, CPU_RST);
    end
    IN_VALID = 1'b1;
    IN_DATA  = 8'hA5;
    repeat (3) step();
    checks++;
    if (IN_READY !== 1'b0 || DONE !== 1'b1 || WE !== 1'b0) begin
      errors++;
      $display("FAIL halt_ignores_bytes: rdy=%b done=%b we=%b, required 0 1 0", IN_READY, DONE, WE);
    end
    IN_VALID = 1'b0;
    pulse_start();
    checks++;
    if (DONE !== 1'b0 || TIMEOUT !== 1'b0 || WORD_CNT !== 16'd0 || IN_READY !== 1'b1) begin
      errors++;
      $display("FAIL halt_restart: done=%b to=%b cnt=%0d rdy=%b, required 0 0 0 1",
               DONE, TIMEOUT, WORD_CNT, IN_READY);
    end
    load_program(1'b0, 1'b0, ok);
    for (int i = 0; i < we_q.size() && i < PW; i++) begin
      checks++;
      if (we_q[i] !== exp_word(i)) begin
        errors++;
        $display("FAIL reload_word%0d: got %h, required %h", i, we_q[i], exp_word(i));
      end
    end
    run_until_stop(1, 1'b0, low);
    checks++;
    if (low != 1 || DONE !== 1'b1 || TIMEOUT !== 1'b0) begin
      errors++;
      $display("FAIL halt_first_cycle: low=%0d done=%b to=%b, required 1 1 0", low, DONE, TIMEOUT);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int low;
    pulse_start();
    load_program(1'b0, 1'b0, ok);
    run_until_stop(0, 1'b0, low);
    checks++;
    if (!ok || low != RC || DONE !== 1'b1 || TIMEOUT !== 1'b1 || CPU_RST !== 1'b1) begin
      errors++;
      $display("FAIL timeout: ok=%b low=%0d done=%b to=%b cpu_rst=%b, required 1 %0d 1 1 1",
               ok, low, DONE, TIMEOUT, CPU_RST, RC);
    end
    PC = HALT;
    repeat (4) step();
    checks++;
    if (DONE !== 1'b1 || TIMEOUT !== 1'b1 || CPU_RST !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky: done=%b to=%b cpu_rst=%b, required 1 1 1", DONE, TIMEOUT, CPU_RST);
    end
    PC = rand_pc();
  endtask

  task automatic test_tie_and_start_noise();
    bit ok;
    int low;
    pulse_start();
    load_program(1'b1, 1'b1, ok);
    checks++;
    if (!ok || we_q.size() != PW || CPU_RST !== 1'b0) begin
      errors++;
      $display("FAIL noise_load: ok=%b n=%0d cpu_rst=%b, required 1 %0d 0", ok, we_q.size(), CPU_RST, PW);
    end
    for (int i = 0; i < we_q.size() && i < PW; i++) begin
      checks++;
      if (we_q[i] !== exp_word(i)) begin
        errors++;
        $display("FAIL noise_word%0d: got %h, required %h", i, we_q[i], exp_word(i));
      end
    end
    run_until_stop(RC, 1'b1, low);
    checks++;
    if (low != RC || DONE !== 1'b1 || TIMEOUT !== 1'b0) begin
      errors++;
      $display("FAIL tie: low=%0d done=%b to=%b, required %0d 1 0", low, DONE, TIMEOUT, RC);
    end
  endtask

  task automatic test_random_runs();
    bit ok;
    int low;
    int halt_at;
    int exp_low;
    bit exp_to;
    for (int r = 0; r < 5; r++) begin
      halt_at = $urandom_range(1, 200);
      exp_low = (halt_at <= RC) ? halt_at : RC;
      exp_to  = (halt_at > RC);
      pulse_start();
      load_program(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ok);
      checks++;
      if (!ok || we_q.size() != PW || long_we != 0) begin
        errors++;
        $display("FAIL rand_load%0d: ok=%b n=%0d long=%0d, required 1 %0d 0", r, ok, we_q.size(), long_we, PW);
      end
      for (int i = 0; i < we_q.size() && i < PW; i++) begin
        checks++;
        if (we_q[i] !== exp_word(i)) begin
          errors++;
          $display("FAIL rand_word%0d_%0d: got %h, required %h", r, i, we_q[i], exp_word(i));
        end
      end
      run_until_stop(halt_at, 1'b0, low);
      checks++;
      if (low != exp_low || DONE !== 1'b1 || TIMEOUT !== exp_to) begin
        errors++;
        $display("FAIL rand_run%0d: halt_at=%0d low=%0d done=%b to=%b, required %0d 1 %b",
                 r, halt_at, low, DONE, TIMEOUT, exp_low, exp_to);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_backpressure();
    test_halt();
    test_timeout();
    test_tie_and_start_noise();
    test_random_runs();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
